// File: rtl/key_spi_tx.sv
// SPI mode-0 transmitter for the keyboard link: key codes are queued in a small
// FIFO and each one is sent as a cs_n-framed byte, MSB first.
module key_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               key_in,
  input  logic                     key_valid,
  output logic                     key_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     key_sck,
  output logic                     key_mosi,
  output logic                     key_cs_n
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]      GAP_LAST   = 8'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] level, level_next;
  logic [7:0]  head;
  logic        push, pop;
  logic [7:0]  div_reg, div_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        sck_reg, sck_next;
  logic        mosi_reg, mosi_next;
  logic        cs_n_reg, cs_n_next;
  logic        busy_reg, busy_next;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level      = wr_ptr_reg - rd_ptr_reg;
  assign key_ready  = (level != FULL_LEVEL);
  assign push       = key_valid & key_ready;
  assign head       = mem[rd_ptr_reg[AW-1:0]];
  assign level_next = level + (AW+1)'(push) - (AW+1)'(pop);

  assign fifo_level = level;
  assign busy       = busy_reg;
  assign key_sck    = sck_reg;
  assign key_mosi   = mosi_reg;
  assign key_cs_n   = cs_n_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= key_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      div_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      sck_reg    <= 1'b0;
      mosi_reg   <= 1'b0;
      cs_n_reg   <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_reg + (AW+1)'(push);
      rd_ptr_reg <= rd_ptr_reg + (AW+1)'(pop);
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      sck_reg    <= sck_next;
      mosi_reg   <= mosi_next;
      cs_n_reg   <= cs_n_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg + 8'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    sck_next   = sck_reg;
    mosi_next  = mosi_reg;
    cs_n_next  = cs_n_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        div_next = '0;
        if (level != '0) begin
          pop        = 1'b1;
          shift_next = head;
          bit_next   = '0;
          cs_n_next  = 1'b0;
          mosi_next  = head[7];
          state_next = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          sck_next   = 1'b1;
          state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          sck_next = 1'b0;
          if (bit_reg == 3'd7) begin
            state_next = S_HOLD;
          end else begin
            // Rotate so the next bit sits at [7]; mosi changes only on the falling sck edge.
            bit_next   = bit_reg + 3'd1;
            shift_next = {shift_reg[6:0], shift_reg[7]};
            mosi_next  = shift_reg[6];
            state_next = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          cs_n_next  = 1'b1;
          mosi_next  = 1'b0;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (div_reg == GAP_LAST) begin
          div_next   = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next != S_IDLE) || (level_next != '0);
  end

endmodule

// File: tb/tb_key_spi_tx.sv
// Directed bench for key_spi_tx: one instance at CLK_DIV=2 and one at CLK_DIV=1,
// with a negedge frame decoder recording byte, cs_n-low length and sck activity.
module tb_key_spi_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key0, key1;
  logic       val0, val1;
  logic [1:0] ready_w, busy_w, sck_w, mosi_w, cs_w;
  logic [2:0] lvl0, lvl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_spi_tx #(.CLK_DIV(2), .GAP(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key0), .key_valid(val0),
    .key_ready(ready_w[0]), .busy(busy_w[0]), .fifo_level(lvl0),
    .key_sck(sck_w[0]), .key_mosi(mosi_w[0]), .key_cs_n(cs_w[0])
  );

  key_spi_tx #(.CLK_DIV(1), .GAP(4), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_in(key1), .key_valid(val1),
    .key_ready(ready_w[1]), .busy(busy_w[1]), .fifo_level(lvl1),
    .key_sck(sck_w[1]), .key_mosi(mosi_w[1]), .key_cs_n(cs_w[1])
  );

  // Frame decoder, sampled once per cycle on the falling clk edge.
  int         cyc = 0;
  logic [1:0] p_sck = 2'b00, p_cs = 2'b11, p_mosi = 2'b00;
  int         nfr [2] = '{0, 0};
  int         glitch [2] = '{0, 0};
  int         len_c [2], rise_c [2], tog_c [2];
  logic [7:0] sh [2];
  logic [7:0] rx_byte [2][16];
  int         rx_len [2][16], rx_rises [2][16], rx_tog [2][16], rx_start [2][16];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i] === 1'b0) begin
        if (p_cs[i]) begin
          len_c[i] = 0; rise_c[i] = 0; tog_c[i] = 0; sh[i] = 8'h00;
          if (nfr[i] < 16) rx_start[i][nfr[i]] = cyc;
        end else if (sck_w[i] !== p_sck[i]) begin
          tog_c[i]++;
        end
        len_c[i]++;
        if (sck_w[i] && !p_sck[i]) begin
          sh[i] = {sh[i][6:0], mosi_w[i]};
          rise_c[i]++;
          if (mosi_w[i] !== p_mosi[i]) glitch[i]++;
        end
      end else if (!p_cs[i]) begin
        if (nfr[i] < 16) begin
          rx_byte[i][nfr[i]]  = sh[i];
          rx_len[i][nfr[i]]   = len_c[i];
          rx_rises[i][nfr[i]] = rise_c[i];
          rx_tog[i][nfr[i]]   = tog_c[i];
        end
        nfr[i]++;
      end
      p_sck[i]  = sck_w[i];
      p_cs[i]   = cs_w[i];
      p_mosi[i] = mosi_w[i];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int which, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_w[which] !== 1'b0 && n < limit);
    check("wait_idle_timeout", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int n, nf;
    logic [7:0] t2_bytes [3];
    logic [7:0] t6_bytes [5];
    t2_bytes = '{8'h12, 8'hA5, 8'hFF};
    t6_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst_n = 1'b0; key0 = 8'h00; key1 = 8'h00; val0 = 1'b0; val1 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cs_n", cs_w[0], 1);
    check("rst_sck", sck_w[0], 0);
    check("rst_mosi", mosi_w[0], 0);
    check("rst_ready", ready_w[0], 1);
    check("rst_busy", busy_w[0], 0);
    check("rst_level", lvl0, 0);

    // Single 0x41 frame: latency, length, bits, busy release.
    key0 = 8'h41; val0 = 1'b1;
    tick();
    val0 = 1'b0;
    check("t1_cs_after_accept", cs_w[0], 1);
    check("t1_level_after_accept", lvl0, 1);
    check("t1_busy_after_accept", busy_w[0], 1);
    tick();
    check("t1_cs_low_next", cs_w[0], 0);
    check("t1_mosi_bit7", mosi_w[0], 0);
    check("t1_level_popped", lvl0, 0);
    wait_idle(0, 200, n);
    check("t1_busy_cycles", n, 38);
    check("t1_frames", nfr[0], 1);
    check("t1_byte", rx_byte[0][0], 8'h41);
    check("t1_cs_low_len", rx_len[0][0], 34);
    check("t1_sck_rises", rx_rises[0][0], 8);

    // Three back-to-back codes.
    val0 = 1'b1;
    key0 = 8'h12; tick(); check("t2_level_a", lvl0, 1);
    key0 = 8'hA5; tick(); check("t2_level_b", lvl0, 1);
    key0 = 8'hFF; tick(); check("t2_level_c", lvl0, 2);
    val0 = 1'b0;
    wait_idle(0, 400, n);
    check("t2_frames", nfr[0], 4);
    for (int k = 0; k < 3; k++) begin
      check("t2_byte", rx_byte[0][1+k], t2_bytes[k]);
      check("t2_len", rx_len[0][1+k], 34);
    end
    check("t2_period_1", rx_start[0][2] - rx_start[0][1], 39);
    check("t2_period_2", rx_start[0][3] - rx_start[0][2], 39);
    check("t2_level_drained", lvl0, 0);

    // key_valid held high: five accepts, then back-pressure.
    val0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      key0 = 8'(8'h30 + i);
      check("t3_ready", ready_w[0], 32'(i < 5));
      tick();
    end
    val0 = 1'b0;
    wait_idle(0, 1000, n);
    check("t3_frames", nfr[0], 9);
    for (int k = 0; k < 5; k++) check("t3_byte", rx_byte[0][4+k], 8'(8'h30 + k));

    // CLK_DIV=1 instance: 17-cycle frame, sck toggling every cycle.
    key1 = 8'h80; val1 = 1'b1;
    tick();
    val1 = 1'b0;
    wait_idle(1, 200, n);
    check("t4_frames", nfr[1], 1);
    check("t4_byte", rx_byte[1][0], 8'h80);
    check("t4_len", rx_len[1][0], 17);
    check("t4_rises", rx_rises[1][0], 8);
    check("t4_sck_toggles", rx_tog[1][0], 16);

    // Reset during bit 4 with two codes still queued.
    val0 = 1'b1;
    key0 = 8'hC3; tick();
    key0 = 8'h5A; tick();
    key0 = 8'h99; tick();
    val0 = 1'b0;
    repeat (18) tick();
    check("t5_cs_pre", cs_w[0], 0);
    check("t5_level_pre", lvl0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_cs_n", cs_w[0], 1);
    check("t5_sck", sck_w[0], 0);
    check("t5_mosi", mosi_w[0], 0);
    check("t5_level", lvl0, 0);
    check("t5_ready", ready_w[0], 1);
    check("t5_busy", busy_w[0], 0);
    check("t5_abort_rises", rx_rises[0][9], 5);
    check("t5_abort_bits", rx_byte[0][9], 8'h18);
    nf = nfr[0];
    repeat (100) tick();
    check("t5_no_frame", nfr[0], nf);
    check("t5_cs_idle", cs_w[0], 1);

    // Push with level DEPTH-1 on the same edge as the IDLE pop.
    val0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      key0 = t6_bytes[k];
      tick();
    end
    val0 = 1'b0;
    repeat (36) tick();
    check("t6_level_before", lvl0, 3);
    check("t6_ready_before", ready_w[0], 1);
    check("t6_cs_before", cs_w[0], 1);
    key0 = t6_bytes[4]; val0 = 1'b1;
    tick();
    val0 = 1'b0;
    check("t6_level_after", lvl0, 3);
    check("t6_cs_after", cs_w[0], 0);
    wait_idle(0, 1000, n);
    check("t6_frames", nfr[0], 15);
    for (int k = 0; k < 5; k++) check("t6_byte", rx_byte[0][10+k], t6_bytes[k]);

    check("mosi_stable_at_rise_0", glitch[0], 0);
    check("mosi_stable_at_rise_1", glitch[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
